vga_sync_generator: RTL and testbench

Timing decode stage directly downstream of the horizontal/vertical pixel counters. Consumes the raw h/v count pair and produces registered VGA sync pulses, the active-display qualifier, aligned pixel coordinates, line/frame strobes and a free-running frame counter for the game-logic and pixel-pipeline stages. A vertical-region state machine cross-checks the incoming count sequence and raises a sticky error on any illegal jump. Default geometry is 640x480 @ 60 Hz, 800x525 total.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/vga_v_region_tracker.sv | 76 +++++++
 rtl/vga_sync_generator.sv | 103 ++++++++++
 tb/tb_vga_sync_generator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 timing constants and the vertical-region type for the sync decode stage.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package vga_timing_pkg;

   // Default geometry, in pixels (horizontal) and lines (vertical)
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   // Derived totals and sync windows (sync asserted for START <= count < END)
   localparam int DEF_H_TOTAL       = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL       = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int DEF_HSYNC_START   = DEF_H_ACTIVE + DEF_H_FRONT;
   localparam int DEF_HSYNC_END     = DEF_HSYNC_START + DEF_H_SYNC;
   localparam int DEF_VSYNC_START   = DEF_V_ACTIVE + DEF_V_FRONT;
   localparam int DEF_VSYNC_END     = DEF_VSYNC_START + DEF_V_SYNC;

   // Vertical region of the current line; order matches the legal sequence
   typedef enum logic [1:0] {
      V_ACT  = 2'd0,
      V_FP   = 2'd1,
      V_SYNC = 2'd2,
      V_BP   = 2'd3
   } v_region_t;

   // Region that legally follows r in a well-formed count sequence
   function automatic v_region_t next_region(input v_region_t r);
      v_region_t n;
      case (r)
         V_ACT:   n = V_FP;
         V_FP:    n = V_SYNC;
         V_SYNC:  n = V_BP;
         default: n = V_ACT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vga_v_region_tracker.sv
// Purpose: tracks the vertical region from the incoming counts and flags illegal count sequences (sticky).
// Latency: 1 cycle, state and error are registered on the edge that samples the counts.
// Backpressure: none, a new count pair is consumed every cycle.
module vga_v_region_tracker
   import vga_timing_pkg::*;
#(
   parameter int ACT_LINES  = DEF_V_ACTIVE,
   parameter int FP_LINES   = DEF_V_FRONT,
   parameter int SYNC_LINES = DEF_V_SYNC
) (
   input  logic       pixel_clk,
   input  logic       reset_n,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic       count_ok,
   output v_region_t  v_state,
   output logic       timing_error
);

   // First line of each non-active region; lines from BP_FIRST up to the total are back porch
   localparam logic [9:0] FP_FIRST   = 10'(ACT_LINES);
   localparam logic [9:0] SYNC_FIRST = 10'(ACT_LINES + FP_LINES);
   localparam logic [9:0] BP_FIRST   = 10'(ACT_LINES + FP_LINES + SYNC_LINES);

   v_region_t decoded;
   v_region_t v_next;
   logic      line_edge;
   logic      err_set;

   // Region is only re-evaluated at the start of a line, and never on an out-of-range pair
   assign line_edge = count_ok && (h_count == 10'd0);

   // Region implied by the raw vertical count
   always_comb begin
      decoded = V_BP;
      if (v_count < FP_FIRST)
         decoded = V_ACT;
      else if (v_count < SYNC_FIRST)
         decoded = V_FP;
      else if (v_count < BP_FIRST)
         decoded = V_SYNC;
   end

   // State register
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n)
         v_state <= V_ACT;
      else
         v_state <= v_next;
   end

   // Next state: a legal advance and an illegal jump both load the decoded region (resync)
   always_comb begin
      v_next = v_state;
      if (line_edge && (decoded != v_state))
         v_next = decoded;
   end

   // Error decode: out-of-range counts, or a line-start region that is neither current nor successor
   always_comb begin
      err_set = 1'b0;
      if (!count_ok)
         err_set = 1'b1;
      else if (line_edge && (decoded != v_state) && (decoded != next_region(v_state)))
         err_set = 1'b1;
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n)
         timing_error <= 1'b0;
      else if (err_set)
         timing_error <= 1'b1;
   end

endmodule

// File: rtl/vga_sync_generator.sv
// Purpose: decodes raw h/v counts into registered sync pulses, display qualifier, coordinates, strobes and frame count.
// Latency: exactly 1 cycle for every output, so sync, display_on and coordinates stay aligned.
// Backpressure: none, a new count pair is accepted every cycle.
module vga_sync_generator
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FRONT  = DEF_H_FRONT,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BACK   = DEF_H_BACK,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FRONT  = DEF_V_FRONT,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BACK   = DEF_V_BACK,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       pixel_clk,
   input  logic       reset_n,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_start,
   output logic       frame_start,
   output logic [5:0] frame_count,
   output logic       timing_error
);

   // Totals and windows as 32-bit constant sums, narrowed to the 10-bit compare width
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
   localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
   localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START_C = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_END_C   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START_C = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS_END_C   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

   logic count_ok;
   logic hs_win;
   logic vs_win;
   logic visible;
   logic line_hit;
   logic frame_hit;

   // Input decode; an out-of-range pair suppresses every qualifier for that cycle
   assign count_ok  = (h_count < H_TOTAL_C) && (v_count < V_TOTAL_C);
   assign hs_win    = count_ok && (h_count >= HS_START_C) && (h_count < HS_END_C);
   assign vs_win    = count_ok && (v_count >= VS_START_C) && (v_count < VS_END_C);
   assign visible   = count_ok && (h_count < H_ACT_C) && (v_count < V_ACT_C);
   assign line_hit  = count_ok && (h_count == 10'd0);
   assign frame_hit = line_hit && (v_count == 10'd0);

   // Output registers, all updated on the edge that samples the counts
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         display_on  <= 1'b0;
         pixel_x     <= 10'd0;
         pixel_y     <= 10'd0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= hs_win ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_win ? SYNC_POL : ~SYNC_POL;
         display_on  <= visible;
         pixel_x     <= visible ? h_count : 10'd0;
         pixel_y     <= visible ? v_count : 10'd0;
         line_start  <= line_hit;
         frame_start <= frame_hit;
      end
   end

   // Frame counter advances on the same edge that registers frame_start high; wraps 63 -> 0
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n)
         frame_count <= 6'd0;
      else if (frame_hit)
         frame_count <= frame_count + 6'd1;
   end

   vga_v_region_tracker #(
      .ACT_LINES  (V_ACTIVE),
      .FP_LINES   (V_FRONT),
      .SYNC_LINES (V_SYNC)
   ) u_tracker (
      .pixel_clk    (pixel_clk),
      .reset_n      (reset_n),
      .h_count      (h_count),
      .v_count      (v_count),
      .count_ok     (count_ok),
      .v_state      (),
      .timing_error (timing_error)
   );

endmodule

// File: tb/tb_vga_sync_generator.sv
// Purpose: self-checking bench for vga_sync_generator against a frame-level behavioural model.
// Latency: model expects every output one edge after its inputs are sampled.
// Backpressure: none; inputs are driven on falling edges, outputs checked on the next falling edge.
module tb_vga_sync_generator;
   import vga_timing_pkg::*;

   logic       pixel_clk = 1'b0;
   logic       reset_n   = 1'b0;
   logic [9:0] h_count   = 10'd100;
   logic [9:0] v_count   = 10'd100;
   logic       hsync, vsync, display_on, line_start, frame_start, timing_error;
   logic [9:0] pixel_x, pixel_y;
   logic [5:0] frame_count;

   int errors = 0;
   int checks = 0;

   // Behavioural model state: region index 0..3, sticky error, frame count as plain integers
   int          m_region;
   bit          m_err;
   int          m_fc;
   logic [31:0] exp_vec;
   logic [31:0] obs;

   vga_sync_generator dut (
      .pixel_clk    (pixel_clk),
      .reset_n      (reset_n),
      .h_count      (h_count),
      .v_count      (v_count),
      .hsync        (hsync),
      .vsync        (vsync),
      .display_on   (display_on),
      .pixel_x      (pixel_x),
      .pixel_y      (pixel_y),
      .line_start   (line_start),
      .frame_start  (frame_start),
      .frame_count  (frame_count),
      .timing_error (timing_error)
   );

   always #5 pixel_clk = ~pixel_clk;

   assign obs = {hsync, vsync, display_on, pixel_x, pixel_y, line_start, frame_start, frame_count, timing_error};

   // Region of a line in the 640x480 frame: active, front porch, sync, back porch
   function automatic int region_of(input int v);
      if (v < 480) return 0;
      if (v < 490) return 1;
      if (v < 492) return 2;
      return 3;
   endfunction

   // Drive one count pair for one clock, advancing the model to what the outputs must show afterwards
   task automatic step(input int h, input int v);
      bit         ok;
      int         r;
      logic       hs, vs, de, ls, fs;
      logic [9:0] px, py;
      ok = (h < 800) && (v < 525);
      hs = (ok && h >= 656 && h < 752) ? 1'b0 : 1'b1;
      vs = (ok && v >= 490 && v < 492) ? 1'b0 : 1'b1;
      de = ok && (h < 640) && (v < 480);
      px = de ? 10'(h) : 10'd0;
      py = de ? 10'(v) : 10'd0;
      ls = ok && (h == 0);
      fs = ls && (v == 0);
      if (!ok) begin
         m_err = 1'b1;
      end else if (h == 0) begin
         r = region_of(v);
         if (r != m_region) begin
            if (r != (m_region + 1) % 4) m_err = 1'b1;
            m_region = r;
         end
      end
      if (fs) m_fc = (m_fc + 1) % 64;
      exp_vec = {hs, vs, de, px, py, ls, fs, 6'(m_fc), m_err};
      h_count = 10'(h);
      v_count = 10'(v);
      @(posedge pixel_clk);
      @(negedge pixel_clk);
   endtask

   // Plain reset pulse with model reset; leaves the bench on a falling edge with reset released
   task automatic apply_reset();
      reset_n = 1'b0;
      @(negedge pixel_clk);
      reset_n  = 1'b1;
      m_region = 0;
      m_err    = 1'b0;
      m_fc     = 0;
   endtask

   task automatic test_reset();
      h_count = 10'd100;
      v_count = 10'd100;
      reset_n = 1'b0;
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync); end
      checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync); end
      checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL reset_display_on got %b want 0", display_on); end
      checks++; if ({pixel_x, pixel_y} !== 20'd0) begin errors++; $display("FAIL reset_pixel got %0d,%0d want 0,0", pixel_x, pixel_y); end
      checks++; if ({line_start, frame_start} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {line_start, frame_start}); end
      checks++; if (frame_count !== 6'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
      checks++; if (timing_error !== 1'b0) begin errors++; $display("FAIL reset_timing_error got %b want 0", timing_error); end
      reset_n  = 1'b1;
      m_region = 0;
      m_err    = 1'b0;
      m_fc     = 0;
      step(100, 100);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL reset_first_pair got %h want %h", obs, exp_vec); end
   endtask

   // Two frames; selected lines are driven at every pixel, the rest only at key h positions
   task automatic test_frame_sweep();
      int hl[9] = '{0, 1, 639, 640, 655, 656, 751, 752, 799};
      int hs_cnt, de_cnt, vs_lines;
      bit full;
      for (int f = 0; f < 2; f++) begin
         vs_lines = 0;
         for (int v = 0; v < 525; v++) begin
            full = (v == 0) || (v == 479) || (v == 480) || (v == 489) ||
                   (v == 490) || (v == 491) || (v == 492) || (v == 524);
            hs_cnt = 0;
            de_cnt = 0;
            if (full) begin
               for (int h = 0; h < 800; h++) begin
                  step(h, v);
                  checks++; if (obs !== exp_vec) begin errors++; $display("FAIL sweep h=%0d v=%0d got %h want %h", h, v, obs, exp_vec); end
                  if (hsync === 1'b0) hs_cnt++;
                  if (display_on === 1'b1) de_cnt++;
                  if (h == 0 && vsync === 1'b0) vs_lines++;
               end
               checks++; if (hs_cnt != 96) begin errors++; $display("FAIL hsync_width v=%0d got %0d want 96", v, hs_cnt); end
               checks++; if (de_cnt != ((v < 480) ? 640 : 0)) begin errors++; $display("FAIL line_display v=%0d got %0d want %0d", v, de_cnt, (v < 480) ? 640 : 0); end
            end else begin
               foreach (hl[i]) begin
                  step(hl[i], v);
                  checks++; if (obs !== exp_vec) begin errors++; $display("FAIL sweep h=%0d v=%0d got %h want %h", hl[i], v, obs, exp_vec); end
                  if (hl[i] == 0 && vsync === 1'b0) vs_lines++;
               end
            end
         end
         checks++; if (vs_lines != 2) begin errors++; $display("FAIL vsync_lines frame=%0d got %0d want 2", f, vs_lines); end
      end
      checks++; if (frame_count !== 6'd2) begin errors++; $display("FAIL sweep_frame_count got %0d want 2", frame_count); end
      checks++; if (timing_error !== 1'b0) begin errors++; $display("FAIL sweep_timing_error got %b want 0", timing_error); end
   endtask

   // Reset asserted mid-cycle must clear outputs before the next rising edge
   task automatic test_async_reset();
      step(700, 490);
      checks++; if ({hsync, vsync} !== 2'b00) begin errors++; $display("FAIL async_pre_sync got %b want 00", {hsync, vsync}); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({hsync, vsync} !== 2'b11) begin errors++; $display("FAIL async_sync got %b want 11", {hsync, vsync}); end
      checks++; if (frame_count !== 6'd0) begin errors++; $display("FAIL async_frame_count got %0d want 0", frame_count); end
      @(negedge pixel_clk);
      reset_n  = 1'b1;
      m_region = 0;
      m_err    = 1'b0;
      m_fc     = 0;
      step(701, 490);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL async_after got %h want %h", obs, exp_vec); end
   endtask

   task automatic test_display_edge();
      step(639, 479);
      checks++; if (display_on !== 1'b1 || pixel_x !== 10'd639 || pixel_y !== 10'd479) begin
         errors++; $display("FAIL edge_last_pixel got de=%b x=%0d y=%0d want de=1 x=639 y=479", display_on, pixel_x, pixel_y); end
      step(640, 479);
      checks++; if (display_on !== 1'b0 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
         errors++; $display("FAIL edge_past_pixel got de=%b x=%0d y=%0d want de=0 x=0 y=0", display_on, pixel_x, pixel_y); end
   endtask

   task automatic test_region_jump();
      apply_reset();
      step(0, 100);
      checks++; if (timing_error !== 1'b0) begin errors++; $display("FAIL jump_before got %b want 0", timing_error); end
      step(0, 495);
      checks++; if (timing_error !== 1'b1) begin errors++; $display("FAIL jump_error got %b want 1", timing_error); end
      checks++; if (dut.u_tracker.v_state !== V_BP) begin errors++; $display("FAIL jump_state got %0d want %0d", dut.u_tracker.v_state, V_BP); end
      step(5, 495);
      step(0, 496);
      checks++; if (obs !== exp_vec || timing_error !== 1'b1) begin errors++; $display("FAIL jump_sticky got %h want %h", obs, exp_vec); end
   endtask

   task automatic test_out_of_range();
      apply_reset();
      step(700, 600);
      checks++; if (timing_error !== 1'b1) begin errors++; $display("FAIL oor_v_error got %b want 1", timing_error); end
      checks++; if ({hsync, vsync, display_on} !== 3'b110) begin errors++; $display("FAIL oor_v_outputs got %b want 110", {hsync, vsync, display_on}); end
      apply_reset();
      step(800, 0);
      checks++; if (obs !== exp_vec || timing_error !== 1'b1 || line_start !== 1'b0) begin
         errors++; $display("FAIL oor_h got %h want %h", obs, exp_vec); end
   endtask

   task automatic test_frame_wrap();
      apply_reset();
      for (int k = 1; k <= 64; k++) begin
         step(0, 0);
         checks++; if (frame_count !== 6'(k % 64) || frame_start !== 1'b1) begin
            errors++; $display("FAIL wrap k=%0d got fc=%0d fs=%b want fc=%0d fs=1", k, frame_count, frame_start, k % 64); end
         step(1, 0);
      end
   endtask

   // Holding the count at 0 re-asserts strobes every cycle
   task automatic test_count_hold();
      apply_reset();
      for (int k = 1; k <= 3; k++) begin
         step(0, 0);
         checks++; if ({line_start, frame_start} !== 2'b11 || frame_count !== 6'(k)) begin
            errors++; $display("FAIL hold k=%0d got ls/fs=%b fc=%0d want 11 fc=%0d", k, {line_start, frame_start}, frame_count, k); end
      end
      step(0, 5);
      checks++; if ({line_start, frame_start} !== 2'b10) begin errors++; $display("FAIL hold_line_only got %b want 10", {line_start, frame_start}); end
   endtask

   task automatic test_random();
      int h, v, r;
      v = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 500 == 0) begin
            apply_reset();
            v = 0;
         end
         r = $urandom_range(0, 99);
         if (r < 2)       v = $urandom_range(0, 1023);
         else if (r < 40) v = (v + 1) % 525;
         h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 849);
         step(h, v);
         checks++; if (obs !== exp_vec) begin errors++; $display("FAIL random n=%0d h=%0d v=%0d got %h want %h", n, h, v, obs, exp_vec); end
      end
   endtask

   initial begin
      test_reset();
      test_frame_sweep();
      test_async_reset();
      test_display_edge();
      test_region_jump();
      test_out_of_range();
      test_frame_wrap();
      test_count_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
